conv33_window_sched: RTL

- Sequencing controller for the 3x3 convolution input stage.
- Accepts one 3x3 window at a time from the sliding-window generator and pulses the load strobe into the 3x3 input buffer.
- Holds the buffer output stable while a single 3x3 MAC array is time-shared across OUT_CH output channels.
- Per channel: selects the weight set, waits out the MAC latency, and hands each channel result downstream with valid/ready backpressure.

---
 rtl/conv33_window_sched_pkg.sv | 22 ++
 rtl/conv33_lat_timer.sv | 39 +++
 rtl/conv33_window_sched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/conv33_window_sched_pkg.sv
// Shared definitions for the 3x3 convolution window scheduler.
// Holds the controller state encoding, the default channel count and
// MAC latency, and a helper that sizes the latency counter.
package conv33_window_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  localparam int DEF_OUT_CH  = 8;
  localparam int DEF_MAC_LAT = 2;

  // Counter width able to hold MAC_LAT-1 (at least one bit).
  function automatic int lat_width(input int mac_lat);
    return (mac_lat > 1) ? $clog2(mac_lat) : 1;
  endfunction

endpackage

// File: rtl/conv33_lat_timer.sv
// Loadable down-counter that times the MAC latency.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clr       synchronous clear to zero (wins over load)
//   load      capture value into the counter
//   value     load value (normally MAC_LAT-1)
//   expire    high when the count is 1, or always when MAC_LAT==1
module conv33_lat_timer
  import conv33_window_sched_pkg::*;
#(
  parameter int MAC_LAT = DEF_MAC_LAT,
  parameter int TW      = lat_width(MAC_LAT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic [TW-1:0] value,
  output logic          expire
);

  logic [TW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - TW'(1);
    end
  end

  // With a single-cycle MAC there is nothing to count down.
  assign expire = (MAC_LAT == 1) || (count_q == TW'(1));

endmodule

// File: rtl/conv33_window_sched.sv
// Sequencing controller for the 3x3 convolution input stage.
// Accepts one window, pulses the input-buffer load, then time-shares a
// single 3x3 MAC array across OUT_CH output channels, handing each channel
// result downstream with valid/ready backpressure.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   flush              synchronous abort back to IDLE
//   win_valid/ready    upstream window handshake
//   inputbuf_load      one-cycle capture strobe for the input buffer
//   inputbuf_read_en   buffer output hold during compute
//   mac_en, weight_sel MAC issue strobe and weight bank for the channel
//   res_valid/ready    downstream result handshake
//   res_oc, res_last   channel tag and last-channel marker
//   busy, win_count    activity flag and completed-window counter
module conv33_window_sched
  import conv33_window_sched_pkg::*;
#(
  parameter int OUT_CH  = DEF_OUT_CH,
  parameter int OC_W    = 3,
  parameter int MAC_LAT = DEF_MAC_LAT,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             win_valid,
  output logic             win_ready,
  output logic             inputbuf_load,
  output logic             inputbuf_read_en,
  output logic             mac_en,
  output logic [OC_W-1:0]  weight_sel,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OC_W-1:0]  res_oc,
  output logic             res_last,
  output logic             busy,
  output logic [CNT_W-1:0] win_count
);

  localparam int              TW       = lat_width(MAC_LAT);
  localparam logic [OC_W-1:0] OC_LAST  = OC_W'(OUT_CH - 1);
  localparam logic [TW-1:0]   LAT_LOAD = TW'(MAC_LAT - 1);

  state_t           state_q, state_d;
  logic [OC_W-1:0]  oc_q;
  logic [CNT_W-1:0] win_count_q;
  logic             oc_last;
  logic             lat_expire;

  assign oc_last = (oc_q == OC_LAST);

  conv33_lat_timer #(
    .MAC_LAT (MAC_LAT),
    .TW      (TW)
  ) u_lat_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .load   (state_q == S_ISSUE),
    .value  (LAT_LOAD),
    .expire (lat_expire)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (win_valid) state_d = S_LOAD;
        S_LOAD:   state_d = S_ISSUE;
        S_ISSUE:  state_d = (MAC_LAT > 1) ? S_WAIT : S_RESULT;
        S_WAIT:   if (lat_expire) state_d = S_RESULT;
        S_RESULT: if (res_ready) state_d = oc_last ? S_IDLE : S_ISSUE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Channel index and completed-window counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oc_q        <= '0;
      win_count_q <= '0;
    end else if (flush) begin
      oc_q <= '0;
    end else begin
      if (state_q == S_IDLE && win_valid) oc_q <= '0;
      if (state_q == S_RESULT && res_ready) begin
        if (oc_last) win_count_q <= win_count_q + CNT_W'(1);
        else         oc_q        <= oc_q + OC_W'(1);
      end
    end
  end

  // Outputs; accept is blocked while flush is asserted
  always_comb begin
    win_ready        = 1'b0;
    inputbuf_load    = 1'b0;
    inputbuf_read_en = 1'b0;
    mac_en           = 1'b0;
    weight_sel       = '0;
    res_valid        = 1'b0;
    res_oc           = '0;
    res_last         = 1'b0;
    busy             = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy          = 1'b0;
        win_ready     = ~flush;
        inputbuf_load = win_valid & ~flush;
      end
      S_LOAD: begin
        weight_sel = oc_q;
      end
      S_ISSUE: begin
        inputbuf_read_en = 1'b1;
        mac_en           = 1'b1;
        weight_sel       = oc_q;
      end
      S_WAIT: begin
        inputbuf_read_en = 1'b1;
        weight_sel       = oc_q;
      end
      S_RESULT: begin
        inputbuf_read_en = 1'b1;
        weight_sel       = oc_q;
        res_valid        = 1'b1;
        res_oc           = oc_q;
        res_last         = oc_last;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign win_count = win_count_q;

endmodule
